// File: rtl/bmm_arb_pkg.sv
// Shared types and constants for the bit-masked memory arbiter.
package bmm_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } state_e;

  localparam int unsigned AddrWDef = 3;
  localparam int unsigned DataWDef = 32;
  localparam int unsigned RdLatMin = 1;
  localparam int unsigned RdLatMax = 4;

endpackage

// File: rtl/bitmask_mem_arbiter_rr_arbiter.sv
// Combinational round-robin pick: searches upward from last_i + 1 with wrap.
module rr_arbiter #(
  parameter int unsigned NumReq = 2,
  parameter int unsigned IdxW   = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [IdxW-1:0]   last_i,
  output logic [NumReq-1:0] gnt_o,
  output logic [IdxW-1:0]   idx_o,
  output logic              valid_o
);

  logic [IdxW-1:0] cand;
  logic            found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned i = 1; i <= NumReq; i++) begin
      cand = IdxW'((32'(last_i) + i) % NumReq);
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/bitmask_mem_arbiter.sv
// Round-robin sequencer sharing one bit-masked memory between NumReq requesters,
// one access in flight, one enable cycle per access.
module bitmask_mem_arbiter
  import bmm_arb_pkg::*;
#(
  parameter int unsigned NumReq = 2,
  parameter int unsigned AddrW  = AddrWDef,
  parameter int unsigned DataW  = DataWDef,
  parameter int unsigned RdLat  = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NumReq-1:0]        req_valid_i,
  output logic [NumReq-1:0]        req_ready_o,
  input  logic [NumReq-1:0]        req_wr_i,
  input  logic [NumReq*AddrW-1:0]  req_addr_i,
  input  logic [NumReq*DataW-1:0]  req_data_i,
  input  logic [NumReq*DataW-1:0]  req_mask_i,
  output logic [NumReq-1:0]        rsp_valid_o,
  output logic [DataW-1:0]         rsp_data_o,
  output logic                     busy_o,
  output logic                     mem_enb_o,
  output logic                     mem_wr_o,
  output logic [AddrW-1:0]         mem_addr_o,
  output logic [DataW-1:0]         mem_data_o,
  output logic [DataW-1:0]         mem_masked_o,
  input  logic [DataW-1:0]         mem_r_data_i
);

  localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int unsigned LatW = $clog2(RdLatMax);
  localparam int unsigned RdLatC = (RdLat < RdLatMin) ? RdLatMin :
                                   (RdLat > RdLatMax) ? RdLatMax : RdLat;
  localparam logic [LatW-1:0] LatInit = LatW'(RdLatC - 1);

  state_e              state_q;
  logic [IdxW-1:0]     gnt_q;
  logic [IdxW-1:0]     last_q;
  logic [LatW-1:0]     lat_q;
  logic                mem_enb_q;
  logic                mem_wr_q;
  logic [AddrW-1:0]    mem_addr_q;
  logic [DataW-1:0]    mem_data_q;
  logic [DataW-1:0]    mem_mask_q;
  logic [NumReq-1:0]   rsp_valid_q;
  logic [DataW-1:0]    rsp_data_q;

  logic [NumReq-1:0]   arb_gnt;
  logic [IdxW-1:0]     arb_idx;
  logic                arb_valid;
  logic [NumReq-1:0]   gnt_oh;

  rr_arbiter #(
    .NumReq (NumReq),
    .IdxW   (IdxW)
  ) u_rr_arbiter (
    .req_i   (req_valid_i),
    .last_i  (last_q),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  assign gnt_oh = NumReq'(1) << gnt_q;

  // mem_* and rsp_* default to zero every cycle so only ISSUE/RESP ever drive them.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      gnt_q       <= '0;
      last_q      <= IdxW'(NumReq - 1);
      lat_q       <= '0;
      mem_enb_q   <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      mem_mask_q  <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      mem_enb_q   <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      mem_mask_q  <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      unique case (state_q)
        StIdle: begin
          if (arb_valid) begin
            gnt_q      <= arb_idx;
            mem_enb_q  <= 1'b1;
            mem_wr_q   <= req_wr_i[arb_idx];
            mem_addr_q <= req_addr_i[32'(arb_idx) * AddrW +: AddrW];
            mem_data_q <= req_data_i[32'(arb_idx) * DataW +: DataW];
            mem_mask_q <= req_mask_i[32'(arb_idx) * DataW +: DataW];
            state_q    <= StIssue;
          end
        end
        StIssue: begin
          if (mem_wr_q) begin
            rsp_valid_q <= gnt_oh;
            state_q     <= StResp;
          end else begin
            lat_q   <= LatInit;
            state_q <= StWait;
          end
        end
        StWait: begin
          if (lat_q == '0) begin
            rsp_data_q  <= mem_r_data_i;
            rsp_valid_q <= gnt_oh;
            state_q     <= StResp;
          end else begin
            lat_q <= lat_q - 1'b1;
          end
        end
        StResp: begin
          last_q  <= gnt_q;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Ready is combinational in the accept cycle; masked during reset.
  assign req_ready_o  = (state_q == StIdle && !rst_i) ? arb_gnt : '0;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_data_o   = rsp_data_q;
  assign busy_o       = (state_q != StIdle);
  assign mem_enb_o    = mem_enb_q;
  assign mem_wr_o     = mem_wr_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_data_o   = mem_data_q;
  assign mem_masked_o = mem_mask_q;

endmodule

// File: tb/tb_bitmask_mem_arbiter.sv
// Directed bench: RdLat=1 instance with a masked memory model, RdLat=3 instance with a
// hand-driven read-data sequence.
module tb_bitmask_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;

  logic [1:0]  req_valid, req_ready, req_wr, rsp_valid;
  logic [5:0]  req_addr;
  logic [63:0] req_data, req_mask;
  logic [31:0] rsp_data, mem_data, mem_masked, mem_r_data;
  logic        busy, mem_enb, mem_wr;
  logic [2:0]  mem_addr;

  logic [1:0]  req_valid3, req_ready3, req_wr3, rsp_valid3;
  logic [5:0]  req_addr3;
  logic [63:0] req_data3, req_mask3;
  logic [31:0] rsp_data3, mem_data3, mem_masked3, mem_r_data3;
  logic        busy3, mem_enb3, mem_wr3;
  logic [2:0]  mem_addr3;

  logic [31:0] mem_arr [8];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  bitmask_mem_arbiter #(.NumReq(2), .AddrW(3), .DataW(32), .RdLat(1)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_wr_i(req_wr),
    .req_addr_i(req_addr), .req_data_i(req_data), .req_mask_i(req_mask),
    .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data), .busy_o(busy),
    .mem_enb_o(mem_enb), .mem_wr_o(mem_wr), .mem_addr_o(mem_addr),
    .mem_data_o(mem_data), .mem_masked_o(mem_masked), .mem_r_data_i(mem_r_data)
  );

  bitmask_mem_arbiter #(.NumReq(2), .AddrW(3), .DataW(32), .RdLat(3)) dut3 (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid3), .req_ready_o(req_ready3), .req_wr_i(req_wr3),
    .req_addr_i(req_addr3), .req_data_i(req_data3), .req_mask_i(req_mask3),
    .rsp_valid_o(rsp_valid3), .rsp_data_o(rsp_data3), .busy_o(busy3),
    .mem_enb_o(mem_enb3), .mem_wr_o(mem_wr3), .mem_addr_o(mem_addr3),
    .mem_data_o(mem_data3), .mem_masked_o(mem_masked3), .mem_r_data_i(mem_r_data3)
  );

  // 8x32 bit-masked memory, one-cycle read latency, every word preset to 0xFFE00000.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) mem_arr[i] <= 32'hFFE0_0000;
      mem_r_data <= '0;
    end else if (mem_enb) begin
      if (mem_wr) mem_arr[mem_addr] <= (mem_arr[mem_addr] & ~mem_masked) | (mem_data & mem_masked);
      else        mem_r_data <= mem_arr[mem_addr];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  int          grants;
  logic [1:0]  exp_g;

  initial begin
    rst = 1'b1;
    req_valid = 2'b11; req_wr = '0; req_addr = '0; req_data = '0; req_mask = '0;
    req_valid3 = '0; req_wr3 = '0; req_addr3 = '0; req_data3 = '0; req_mask3 = '0;
    mem_r_data3 = '0;

    // Reset held for two cycles with both requesters valid.
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      step();
      #1;
      check_eq("rst_ready", 32'(req_ready), 0);
      check_eq("rst_rsp_valid", 32'(rsp_valid), 0);
      check_eq("rst_mem_enb", 32'(mem_enb), 0);
      check_eq("rst_busy", 32'(busy), 0);
    end
    rst = 1'b0; req_valid = '0;
    step();

    // Masked write from requester 0.
    req_valid = 2'b01; req_wr = 2'b01; req_addr = {3'd0, 3'd3};
    req_data = {32'd0, 32'h0000_003F}; req_mask = {32'd0, 32'h0000_03FF};
    #1 check_eq("wr_ready", 32'(req_ready), 32'h1);
    step();
    check_eq("wr_enb", 32'(mem_enb), 1);
    check_eq("wr_wr", 32'(mem_wr), 1);
    check_eq("wr_addr", 32'(mem_addr), 3);
    check_eq("wr_data", mem_data, 32'h3F);
    check_eq("wr_mask", mem_masked, 32'h3FF);
    check_eq("wr_busy", 32'(busy), 1);
    req_valid = '0;
    step();
    check_eq("wr_enb_off", 32'(mem_enb), 0);
    check_eq("wr_rsp_valid", 32'(rsp_valid), 32'h1);
    check_eq("wr_rsp_data", rsp_data, 0);
    step();
    check_eq("wr_rsp_done", 32'(rsp_valid), 0);

    // Read back from requester 1; memory holds 0xFFE0003F after the masked write.
    req_valid = 2'b10; req_wr = 2'b00; req_addr = {3'd3, 3'd0};
    #1 check_eq("rd_ready", 32'(req_ready), 32'h2);
    step();
    check_eq("rd_enb", 32'(mem_enb), 1);
    check_eq("rd_wr", 32'(mem_wr), 0);
    check_eq("rd_addr", 32'(mem_addr), 3);
    req_valid = '0;
    step();
    check_eq("rd_wait_enb", 32'(mem_enb), 0);
    check_eq("rd_wait_rsp", 32'(rsp_valid), 0);
    step();
    check_eq("rd_rsp_valid", 32'(rsp_valid), 32'h2);
    check_eq("rd_rsp_data", rsp_data, 32'hFFE0_003F);
    step();

    // Contention: both valid for 12 accesses; grants must alternate starting at 0.
    req_valid = 2'b11; req_wr = 2'b11; req_addr = {3'd6, 3'd5};
    req_data = '1; req_mask = '0;
    exp_g = 2'b01; grants = 0;
    for (int cyc = 0; cyc < 60 && grants < 12; cyc++) begin
      #1;
      if (req_ready != 2'b00) begin
        check_eq("cont_gnt", 32'(req_ready), 32'(exp_g));
        exp_g = {exp_g[0], exp_g[1]};
        grants++;
      end
      if (grants < 12) step();
    end
    if (grants != 12) check_eq("cont_timeout", grants, 12);
    step();
    req_valid = '0;
    step();
    step();

    // Lone requester 1 held valid: granted every third cycle.
    req_valid = 2'b10;
    for (int k = 0; k < 7; k++) begin
      #1 check_eq("solo_ready", 32'(req_ready), (k % 3 == 0) ? 32'h2 : 32'h0);
      step();
    end
    req_valid = '0;
    step();
    step();

    // Requester 0 completes a write, then requester 1's read is cut by reset in WAIT.
    req_valid = 2'b01; req_wr = 2'b01;
    step();
    req_valid = '0;
    step();
    step();
    req_valid = 2'b10; req_wr = 2'b00;
    #1 check_eq("pre_rst_ready", 32'(req_ready), 32'h2);
    step();
    req_valid = '0;
    step();
    rst = 1'b1; req_valid = 2'b11; req_wr = 2'b11;
    step();
    check_eq("mid_rst_rsp", 32'(rsp_valid), 0);
    check_eq("mid_rst_enb", 32'(mem_enb), 0);
    check_eq("mid_rst_busy", 32'(busy), 0);
    rst = 1'b0;
    #1 check_eq("post_rst_ready", 32'(req_ready), 32'h1);
    step();
    req_valid = '0;
    step();
    check_eq("post_rst_rsp", 32'(rsp_valid), 32'h1);
    step();

    // RdLat=3: read of addr 7, data must come from the third cycle after enable.
    req_valid3 = 2'b01; req_wr3 = 2'b00; req_addr3 = {3'd0, 3'd7};
    #1 check_eq("l3_ready", 32'(req_ready3), 32'h1);
    step();
    check_eq("l3_enb", 32'(mem_enb3), 1);
    check_eq("l3_addr", 32'(mem_addr3), 7);
    req_valid3 = '0;
    step();
    check_eq("l3_enb_off", 32'(mem_enb3), 0);
    mem_r_data3 = 32'h1111_1111;
    step();
    mem_r_data3 = 32'h2222_2222;
    step();
    check_eq("l3_early_rsp", 32'(rsp_valid3), 0);
    mem_r_data3 = 32'hC0FF_EE07;
    step();
    check_eq("l3_rsp_valid", 32'(rsp_valid3), 32'h1);
    check_eq("l3_rsp_data", rsp_data3, 32'hC0FF_EE07);
    mem_r_data3 = 32'h4444_4444;
    step();
    check_eq("l3_idle", 32'(busy3), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
